grf_mp: RTL and testbench
=========================

Name: grf_mp

Overview:
- Parametrised successor to the single-write/two-read general register file.
- Provides NUM_RD bypassed read ports, one write port, and hardwired register 0.
- Adds a per-register pending-write scoreboard, so the pipelined CPU hazard unit can stall on in-flight producers.
- Sits between decode (read/allocate) and write-back (write/retire).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- CNT_W, 2, pending-counter width per register; max in-flight writers = 2**CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- we  in  1  write/retire enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wpc  in  32  PC of the writing instruction; used only by the trace feature.
- raddr  in  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  packed read data.
- rbusy  out  NUM_RD  per-port: a pending writer exists for that register.
- alloc_en  in  1  issue: an instruction that will write alloc_addr is issued this cycle.
- alloc_addr  in  ADDR_W  destination being allocated.
- ovf  out  1  sticky: an allocation hit a saturated counter.

Behaviour:
- Reset (async, asserted at any time including mid-operation):
  - All registers = 0, all pending counters = 0, ovf = 0.
  - rdata and rbusy follow combinationally; all read 0 while reset is high.
  - we and alloc_en are ignored while reset is high.
- Write:
  - At posedge clk with we=1 and waddr!=0: reg[waddr] <= wdata.
  - waddr==0: no storage change; still traced.
- Read (combinational, zero latency):
  - raddr_i==0 -> rdata_i=0.
  - Else if we && waddr==raddr_i && waddr!=0 -> rdata_i = wdata (write-through bypass).
  - Else rdata_i = reg[raddr_i].
  - All ports are independent; identical addresses on several ports are legal.
- Pending counter cnt[r], r!=0, updated at posedge clk:
  - inc = alloc_en && alloc_addr==r; dec = we && waddr==r && cnt[r]!=0.
  - inc && !dec: cnt+1, saturating at max. Alloc at max: cnt stays at max, ovf <= 1.
  - dec && !inc: cnt-1.
  - inc && dec (same cycle, same address): cnt unchanged.
  - Write to a register with cnt==0 is an untracked write: data is stored, counter stays 0.
  - cnt[0] is constant 0; alloc_en to address 0 is ignored.
- rbusy_i:
  - 1 iff raddr_i!=0 && cnt[raddr_i]!=0, excluding the retiring-last-writer case (we && waddr==raddr_i && cnt==1), which reads 0 because the bypass supplies the data.
  - An alloc in the same cycle does not affect rbusy; the issuing instruction reads before it allocates.
- ovf: sticky until reset.
- No other latency: writes are visible to reads through the bypass in the same cycle, and from storage in the next cycle.

Optional Feature:
- Macro GRF_TRACE_EN.
- Defined: every posedge with we=1 and reset=0 prints "@%h: $%d <= %h" (wpc, waddr, wdata), including waddr==0 and untracked writes.
- Not defined: no $display; wpc is unused; behaviour is otherwise identical.

Decomposition:
- Package grf_pkg:
  - default DATA_W/ADDR_W/NUM_RD/CNT_W constants;
  - ZERO_REG localparam = 0;
  - typedef for the counter (logic [CNT_W-1:0]).
- Sub-module grf_pending_cnt: one saturating up/down counter with inc, dec, async reset, busy, last, and sat outputs; generate one per register 1..2**ADDR_W-1.
- Storage array and read muxes stay in grf_mp.

Test Plan:
- Reset/zero:
  - Assert reset mid-run after writing reg5=0x12345678 -> rdata for raddr=5 is 0 immediately, without waiting for clk; ovf=0.
  - we=1, waddr=0, wdata=0xFFFFFFFF -> raddr=0 still reads 0 on all ports.
- Bypass:
  - Same cycle we=1, waddr=7, wdata=0xDEADBEEF, raddr0=raddr1=7 -> both rdata=0xDEADBEEF before the edge.
  - After the edge, with we=0 -> still 0xDEADBEEF.
- Scoreboard:
  - alloc 9 twice (cnt=2) -> rbusy=1.
  - One write to 9 -> rbusy stays 1.
  - Second write cycle -> rbusy=0 during that cycle, rdata=wdata.
  - Next cycle cnt=0.
- Simultaneous alloc+write to reg 3 with cnt=1 -> cnt stays 1, rbusy=1 next cycle.
- Saturation (CNT_W=2): alloc reg 4 four times -> cnt=3 and ovf=1 after the 4th edge; three writes bring rbusy to 0.
- Untracked write: write reg 10=0x55 with cnt=0 -> stored, rbusy=0, counter stays 0.
- NUM_RD=4 build: four ports read distinct registers 1,2,3,31 simultaneously -> correct values.
- Trace build: the trace line matches the golden text.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared defaults and types for the grf_mp register file with pending-write scoreboard.
package grf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_CNT_W  = 2;
    localparam int ZERO_REG   = 0;

    typedef logic [DEF_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/grf_pending_cnt.sv
// Saturating up/down counter tracking in-flight writers of one register.
module grf_pending_cnt
    import grf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic last,
    output logic sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             decEff;

    // A write to an idle register is untracked and must not underflow the count.
    assign decEff = dec && busy;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !decEff && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (decEff && !inc) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign last = (cnt_q == CNT_W'(1));
    assign sat  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/grf_mp.sv
// Multi-read-port register file with write-through bypass and per-register pending-writer scoreboard.
// Define GRF_TRACE_EN to print a trace line for every write.
module grf_mp
    import grf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [31:0]              wpc,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic                     ovf
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              ovf_q;
    logic              weEff;
    logic              allocEff;
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  last;
    logic [DEPTH-1:0]  sat;

    // Reset masks the write port too, so the bypass path also reads zero.
    assign weEff    = we && !reset;
    assign allocEff = alloc_en && !reset;

    assign busy[0] = 1'b0;
    assign last[0] = 1'b0;
    assign sat[0]  = 1'b0;

    for (genvar r = 1; r < DEPTH; r++) begin : gCnt
        grf_pending_cnt #(
            .CNT_W (CNT_W)
        ) uCnt (
            .clk   (clk),
            .reset (reset),
            .inc   (allocEff && alloc_addr == ADDR_W'(r)),
            .dec   (weEff && waddr == ADDR_W'(r)),
            .busy  (busy[r]),
            .last  (last[r]),
            .sat   (sat[r])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (weEff && waddr != ZERO_ADDR) begin
            regs_q[waddr] <= wdata;
        end
    end

    // A retire to the same register in the same cycle absorbs the allocation, so it is not an overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (allocEff && alloc_addr != ZERO_ADDR && sat[alloc_addr]
                     && !(weEff && waddr == alloc_addr)) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic              hit;
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        hit   = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra  = raddr[p*ADDR_W +: ADDR_W];
            hit = weEff && (waddr == ra);
            if (ra != ZERO_ADDR) begin
                rdata[p*DATA_W +: DATA_W] = hit ? wdata : regs_q[ra];
                rbusy[p]                  = busy[ra] && !(hit && last[ra]);
            end
        end
    end

`ifdef GRF_TRACE_EN
    always @(posedge clk) begin
        if (!reset && we) begin
            $display("@%h: $%d <= %h", wpc, waddr, wdata);
        end
    end
`else
    logic unusedWpc;
    assign unusedWpc = ^wpc;
`endif

endmodule

// File: tb/tb_grf_mp.sv
// Scoreboard bench for grf_mp: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_grf_mp;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 4;
    localparam int CW   = 2;
    localparam int MAXC = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           we;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic [31:0]    wpc;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]  rbusy;
    logic           alloc_en;
    logic [AW-1:0]  alloc_addr;
    logic           ovf;

    always #5 clk = ~clk;

    grf_mp #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .wpc        (wpc),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .ovf        (ovf)
    );

    typedef struct {
        string          tag;
        logic [NR*DW-1:0] rdata;
        logic [NR-1:0]  rbusy;
        logic           ovf;
    } exp_t;

    exp_t expQ[$];

    // Architectural reference: register contents, outstanding writer counts, sticky overflow.
    logic [DW-1:0] mem  [32];
    int            pend [32];
    bit            ovfM;

    int checks = 0;
    int errors = 0;

    task automatic clearModel();
        for (int i = 0; i < 32; i++) begin
            mem[i]  = '0;
            pend[i] = 0;
        end
        ovfM = 1'b0;
    endtask

    function automatic exp_t buildExpect(input string tag, input bit w, input logic [AW-1:0] wa,
                                         input logic [DW-1:0] wd, input logic [AW-1:0] ra [NR]);
        exp_t e;
        e.tag   = tag;
        e.ovf   = ovfM;
        e.rdata = '0;
        e.rbusy = '0;
        for (int p = 0; p < NR; p++) begin
            if (ra[p] != 0) begin
                e.rdata[p*DW +: DW] = (w && wa == ra[p]) ? wd : mem[ra[p]];
                e.rbusy[p] = (pend[ra[p]] > 0) && !(w && wa == ra[p] && pend[ra[p]] == 1);
            end
        end
        return e;
    endfunction

    task automatic modelStep(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input bit ae, input logic [AW-1:0] aa);
        bit inc;
        bit dec;
        inc = ae && aa != 0;
        dec = w && wa != 0 && pend[wa] > 0;
        if (w && wa != 0) mem[wa] = wd;
        if (!(inc && dec && aa == wa)) begin
            if (dec) pend[wa] = pend[wa] - 1;
            if (inc) begin
                if (pend[aa] == MAXC) ovfM = 1'b1;
                else pend[aa] = pend[aa] + 1;
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input bit w, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input logic [AW-1:0] r0,
                                 input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                                 input logic [AW-1:0] r3, input bit ae, input logic [AW-1:0] aa);
        logic [AW-1:0] ra [NR];
        @(posedge clk);
        #1;
        ra = '{r0, r1, r2, r3};
        we         = w;
        waddr      = wa;
        wdata      = wd;
        wpc        = $urandom;
        alloc_en   = ae;
        alloc_addr = aa;
        for (int p = 0; p < NR; p++) raddr[p*AW +: AW] = ra[p];
        expQ.push_back(buildExpect(tag, w, wa, wd, ra));
        modelStep(w, wa, wd, ae, aa);
    endtask

    task automatic readAll(input string tag, input logic [AW-1:0] a);
        applyStimulus(tag, 0, 0, 0, a, a, a, a, 0, 0);
    endtask

    // Reset lands mid-cycle with write and alloc active; both must be ignored.
    task automatic pulseReset(input string tag, input logic [AW-1:0] a);
        logic [AW-1:0] ra [NR];
        @(posedge clk);
        #1;
        ra = '{a, a, a, a};
        reset      = 1'b1;
        we         = 1'b1;
        waddr      = a;
        wdata      = '1;
        alloc_en   = 1'b1;
        alloc_addr = a;
        for (int p = 0; p < NR; p++) raddr[p*AW +: AW] = ra[p];
        clearModel();
        expQ.push_back(buildExpect(tag, 0, 0, 0, ra));
        @(posedge clk);
        #1;
        reset    = 1'b0;
        we       = 1'b0;
        alloc_en = 1'b0;
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (rdata !== e.rdata) begin
            errors++;
            $display("[TB] FAIL %s rdata got %h expected %h", e.tag, rdata, e.rdata);
        end
        checks++;
        if (rbusy !== e.rbusy) begin
            errors++;
            $display("[TB] FAIL %s rbusy got %b expected %b", e.tag, rbusy, e.rbusy);
        end
        checks++;
        if (ovf !== e.ovf) begin
            errors++;
            $display("[TB] FAIL %s ovf got %b expected %b", e.tag, ovf, e.ovf);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [AW-1:0] pickAddr();
        return ($urandom_range(0, 9) == 0) ? AW'(31) : AW'($urandom_range(0, 11));
    endfunction

    initial begin
        logic [AW-1:0] ra0 [NR];
        reset      = 1'b1;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;
        wpc        = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        raddr      = '0;
        clearModel();
        #1;
        ra0 = '{5, 7, 9, 31};
        for (int p = 0; p < NR; p++) raddr[p*AW +: AW] = ra0[p];
        expQ.push_back(buildExpect("reset0", 0, 0, 0, ra0));
        #11;
        reset = 1'b0;

        applyStimulus("wr5", 1, 5, 32'h1234_5678, 5, 5, 0, 1, 0, 0);
        readAll("rd5", 5);
        pulseReset("midReset", 5);
        readAll("rd5AfterReset", 5);
        applyStimulus("wrZero", 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
        readAll("rdZero", 0);
        applyStimulus("bypass7", 1, 7, 32'hDEAD_BEEF, 7, 7, 1, 2, 0, 0);
        readAll("stored7", 7);

        applyStimulus("alloc9a", 0, 0, 0, 9, 9, 0, 0, 1, 9);
        applyStimulus("alloc9b", 0, 0, 0, 9, 9, 0, 0, 1, 9);
        readAll("busy9", 9);
        applyStimulus("wr9a", 1, 9, 32'hAAAA_0001, 9, 9, 0, 0, 0, 0);
        applyStimulus("wr9b", 1, 9, 32'hBBBB_0002, 9, 9, 0, 0, 0, 0);
        readAll("idle9", 9);

        applyStimulus("alloc3", 0, 0, 0, 3, 0, 0, 0, 1, 3);
        applyStimulus("allocWr3", 1, 3, 32'h0000_0333, 3, 3, 0, 0, 1, 3);
        readAll("still3", 3);
        applyStimulus("wr3", 1, 3, 32'h0000_0334, 3, 0, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) applyStimulus("alloc4", 0, 0, 0, 4, 0, 0, 0, 1, 4);
        readAll("sat4", 4);
        for (int i = 0; i < 3; i++) applyStimulus("drain4", 1, 4, 32'h4000 + i, 4, 4, 0, 0, 0, 0);
        readAll("idle4", 4);

        applyStimulus("untracked10", 1, 10, 32'h55, 10, 0, 0, 0, 0, 0);
        readAll("rd10", 10);

        applyStimulus("wr1", 1, 1, 32'h1111_1111, 0, 0, 0, 0, 0, 0);
        applyStimulus("wr2", 1, 2, 32'h2222_2222, 0, 0, 0, 0, 0, 0);
        applyStimulus("wr3b", 1, 3, 32'h3333_3333, 0, 0, 0, 0, 0, 0);
        applyStimulus("wr31", 1, 31, 32'h3131_3131, 0, 0, 0, 0, 0, 0);
        applyStimulus("fourPorts", 0, 0, 0, 1, 2, 3, 31, 0, 0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulseReset("randReset", pickAddr());
            end else begin
                applyStimulus("random", 1'($urandom_range(0, 1)), pickAddr(), $urandom,
                              pickAddr(), pickAddr(), pickAddr(), pickAddr(),
                              1'($urandom_range(0, 1)), pickAddr());
            end
        end

        applyStimulus("final", 0, 0, 0, 1, 2, 3, 4, 0, 0);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending %0d expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
